sort_responder: RTL and testbench
=================================

# sort_responder

Receive-side partner of the layer-sort initiator in the 3D self-test stack. Each layer hosts one instance. It watches the 32-bit inter-layer bus for a sort request from the layer below and checks the request's power level and ID assignment. It then returns an acknowledge frame that the initiator accepts inside its 15-cycle listen window, and latches the layer's own chip ID.

## Interface
- RESP_LAT, default 2: cycles between request acceptance and ack drive; legal 0..12.
- ACK_HOLD, default 4: cycles the ack frame stays on data_out; legal 1..15.
- MIN_PWR, default 4'd1: minimum request power level accepted (link-budget model).
- TIMEOUT_CYC, default 1023: listen watchdog length; used only with SORT_RESP_TIMEOUT_EN.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- bottom  in  1  layer has no lower neighbour; self-assigns ID 0.
- data_in  in  32  bus from the lower layer.
- data_out  out  32  bus to the lower layer; ack frame or zero.
- ack_valid  out  1  high while the ack frame is driven.
- my_id  out  4  assigned chip ID.
- id_valid  out  1  my_id final.
- pwr_seen  out  4  power level of the accepted request.
- err_id  out  1  one-cycle pulse on a malformed ID assignment.
- timeout  out  1  watchdog expired; sticky until reset.

## Operation
- Request frame fields:
  - [31:28] = 4'hA
  - [27:24] = pwr
  - [23:20] = src_id
  - [19:16] = asg_id
  - [15:0] = 16'hBEAF
- Ack frame fields:
  - [31:28] = 4'h5
  - [27:24] = pwr
  - [23:20] = asg_id
  - [19:16] = src_id
  - [15:0] = 16'hBEAF
  - asg_id sits in [23:20] because that is where the initiator checks for chip_id+1.
- States and transitions:
  - LISTEN:
    - bottom=1 → DONE with my_id=0.
    - Valid request → WAIT.
  - WAIT: counts down RESP_LAT, then → ACK.
  - ACK: holds ACK_HOLD cycles, then → DONE.
  - DONE: terminal; only reset leaves it.
- Valid request, all of the following:
  - header 4'hA and sync 16'hBEAF;
  - pwr >= MIN_PWR;
  - asg_id == (src_id+1) mod 16;
  - asg_id != 0.
- On acceptance: capture pwr, src_id and asg_id; pwr_seen ← pwr.
- Header and sync correct, but ID rule fails (including src_id=15 wrapping to asg_id=0): err_id pulses and the block stays in LISTEN.
- Header and sync correct, but pwr < MIN_PWR: ignored silently with no error. The initiator retries at a higher power.
- Bus content in WAIT, ACK or DONE is ignored; the first accepted request wins.
- On the transition into DONE via ACK: my_id ← asg_id and id_valid ← 1.
- All ID arithmetic is 4-bit with mod-16 wrap.

## Timing
- All outputs are registered. Reset values:
  - data_out = 0
  - ack_valid = 0
  - my_id = 0
  - id_valid = 0
  - pwr_seen = 0
  - err_id = 0
  - timeout = 0
  - state LISTEN
- Request sampled valid at edge N:
  - WAIT is entered at N.
  - ACK is entered at edge N+RESP_LAT+1; data_out and ack_valid are asserted at that edge.
  - data_out returns to 0 at edge N+RESP_LAT+1+ACK_HOLD; id_valid rises at the same edge.
- RESP_LAT=0: the ack appears one edge after acceptance.
- bottom=1: id_valid=1 at the first edge after reset release, and no ack is ever driven.
- err_id is high for exactly one cycle, at the edge after the bad frame is sampled.
- A bad frame held for k cycles produces k pulses.
- Reset mid-operation (WAIT or ACK) immediately forces all reset values; the ack is aborted.

## Configuration
- SORT_RESP_TIMEOUT_EN defined:
  - A listen counter clears on entry to LISTEN and increments each LISTEN cycle.
  - When it reaches TIMEOUT_CYC with no valid request, the block goes to DONE with timeout=1 and id_valid=0.
  - A valid request on the expiry cycle wins over the timeout.
- SORT_RESP_TIMEOUT_EN undefined: no counter, timeout tied to 0, and LISTEN waits indefinitely.

## Structure
- Package sort_pkg holds:
  - SYNC_WORD = 16'hBEAF, HDR_REQ = 4'hA, HDR_ACK = 4'h5;
  - field bit-position constants;
  - the responder state enum (LISTEN, WAIT, ACK, DONE).
- Sub-module sort_frame_dec, purely combinational:
  - decodes data_in into pwr, src_id and asg_id;
  - produces flags hdr_ok, pwr_ok and id_ok.
- sort_responder holds the FSM, the counters and the output registers.

## Test plan
- bottom=0, defaults, data_in=32'hA301BEAF (pwr 3, src 0, asg 1) for 1 cycle → ack_valid for 4 cycles starting 3 edges later with data_out=32'h5310BEAF; then my_id=1, id_valid=1, pwr_seen=3.
- MIN_PWR=4, data_in=32'hA301BEAF then 32'hA401BEAF → first frame ignored (no err_id, no ack); second frame gives ack 32'h5410BEAF.
- data_in=32'hA203BEAF (asg 3 ≠ src 0+1) → err_id pulses 1 cycle, state stays LISTEN, data_out=0; a following 32'hA201BEAF is accepted.
- data_in=32'hA2F0BEAF (src 15 wraps to asg 0) → err_id pulse, no ack.
- Accepted request, then a second valid request during WAIT, then rst_n low during ACK → second request ignored; reset clears data_out, ack_valid and id_valid at once.
- SORT_RESP_TIMEOUT_EN with TIMEOUT_CYC=16 and an idle bus → timeout=1 and state DONE after 16 cycles, id_valid=0; bottom=1 case gives id_valid=1 with my_id=0 one edge after reset release.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared constants, field positions and state type for the layer-sort
// request/acknowledge protocol.
package sort_pkg;

  localparam logic [15:0] SYNC_WORD = 16'hBEAF;
  localparam logic [3:0]  HDR_REQ   = 4'hA;
  localparam logic [3:0]  HDR_ACK   = 4'h5;

  // Field LSB positions inside a 32-bit bus word.
  localparam int unsigned HDR_LSB  = 28;
  localparam int unsigned PWR_LSB  = 24;
  localparam int unsigned F1_LSB   = 20;  // request: src_id, ack: asg_id
  localparam int unsigned F0_LSB   = 16;  // request: asg_id, ack: src_id
  localparam int unsigned SYNC_LSB = 0;

  typedef enum logic [1:0] {
    LISTEN = 2'd0,
    WAIT   = 2'd1,
    ACK    = 2'd2,
    DONE   = 2'd3
  } resp_state_e;

  // Ack frame: asg_id goes where the initiator looks for chip_id+1.
  function automatic logic [31:0] build_ack(input logic [3:0] pwr,
                                            input logic [3:0] asg_id,
                                            input logic [3:0] src_id);
    return {HDR_ACK, pwr, asg_id, src_id, SYNC_WORD};
  endfunction

endpackage

// File: rtl/sort_frame_dec.sv
// Combinational decoder for a sort request frame on the inter-layer bus.
module sort_frame_dec
  import sort_pkg::*;
#(
  parameter logic [3:0] MIN_PWR = 4'd1
) (
  input  logic [31:0] data_in,
  output logic [3:0]  pwr,
  output logic [3:0]  src_id,
  output logic [3:0]  asg_id,
  output logic        hdr_ok,
  output logic        pwr_ok,
  output logic        id_ok
);

  logic [3:0] src_inc;

  // Field extraction and validity flags; ID arithmetic wraps mod 16.
  always_comb begin
    pwr     = data_in[PWR_LSB +: 4];
    src_id  = data_in[F1_LSB +: 4];
    asg_id  = data_in[F0_LSB +: 4];
    src_inc = src_id + 4'd1;
    hdr_ok  = (data_in[HDR_LSB +: 4] == HDR_REQ) &&
              (data_in[SYNC_LSB +: 16] == SYNC_WORD);
    pwr_ok  = (pwr >= MIN_PWR);
    id_ok   = (asg_id == src_inc) && (asg_id != 4'd0);
  end

endmodule

// File: rtl/sort_responder.sv
// Layer-sort responder: accepts one sort request from the lower layer,
// returns an ack frame after RESP_LAT cycles for ACK_HOLD cycles, then
// latches the assigned chip ID. Optional listen watchdog enabled by
// defining SORT_RESP_TIMEOUT_EN.
module sort_responder
  import sort_pkg::*;
#(
  parameter int unsigned RESP_LAT    = 2,
  parameter int unsigned ACK_HOLD    = 4,
  parameter logic [3:0]  MIN_PWR     = 4'd1,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bottom,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack_valid,
  output logic [3:0]  my_id,
  output logic        id_valid,
  output logic [3:0]  pwr_seen,
  output logic        err_id,
  output logic        timeout
);

  resp_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  src_q, src_d;
  logic [3:0]  asg_q, asg_d;
  logic [3:0]  pwr_seen_q, pwr_seen_d;
  logic [31:0] data_out_q, data_out_d;
  logic        ack_valid_q, ack_valid_d;
  logic [3:0]  my_id_q, my_id_d;
  logic        id_valid_q, id_valid_d;
  logic        err_id_q, err_id_d;
  logic        timeout_q, timeout_d;

  logic [3:0]  dec_pwr, dec_src, dec_asg;
  logic        hdr_ok, pwr_ok, id_ok;
  logic        expire;

  sort_frame_dec #(
    .MIN_PWR (MIN_PWR)
  ) u_dec (
    .data_in (data_in),
    .pwr     (dec_pwr),
    .src_id  (dec_src),
    .asg_id  (dec_asg),
    .hdr_ok  (hdr_ok),
    .pwr_ok  (pwr_ok),
    .id_ok   (id_ok)
  );

`ifdef SORT_RESP_TIMEOUT_EN
  localparam int unsigned LCW = $clog2(TIMEOUT_CYC + 1);
  logic [LCW-1:0] lcnt_q, lcnt_d;

  // Listen watchdog: counts LISTEN cycles, zero everywhere else.
  always_comb begin
    lcnt_d = '0;
    if (state_q == LISTEN) lcnt_d = lcnt_q + 1'b1;
    expire = (state_q == LISTEN) && (lcnt_q == LCW'(TIMEOUT_CYC - 1));
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lcnt_q <= '0;
    else        lcnt_q <= lcnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign expire = 1'b0;
`endif

  // Next-state and next-output logic; outputs are computed one edge
  // ahead so every port comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    src_d       = src_q;
    asg_d       = asg_q;
    pwr_seen_d  = pwr_seen_q;
    data_out_d  = data_out_q;
    ack_valid_d = ack_valid_q;
    my_id_d     = my_id_q;
    id_valid_d  = id_valid_q;
    err_id_d    = 1'b0;
    timeout_d   = timeout_q;

    case (state_q)
      LISTEN: begin
        if (bottom) begin
          state_d    = DONE;
          my_id_d    = '0;
          id_valid_d = 1'b1;
        end else if (hdr_ok && pwr_ok && id_ok) begin
          state_d    = WAIT;
          cnt_d      = 4'(RESP_LAT);
          src_d      = dec_src;
          asg_d      = dec_asg;
          pwr_seen_d = dec_pwr;
        end else begin
          if (hdr_ok && !id_ok) err_id_d = 1'b1;
          if (expire) begin
            state_d   = DONE;
            timeout_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = ACK;
          cnt_d       = 4'(ACK_HOLD - 1);
          data_out_d  = build_ack(pwr_seen_q, asg_q, src_q);
          ack_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        if (cnt_q == '0) begin
          state_d     = DONE;
          data_out_d  = '0;
          ack_valid_d = 1'b0;
          my_id_d     = asg_q;
          id_valid_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = LISTEN;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LISTEN;
      cnt_q       <= '0;
      src_q       <= '0;
      asg_q       <= '0;
      pwr_seen_q  <= '0;
      data_out_q  <= '0;
      ack_valid_q <= 1'b0;
      my_id_q     <= '0;
      id_valid_q  <= 1'b0;
      err_id_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src_q       <= src_d;
      asg_q       <= asg_d;
      pwr_seen_q  <= pwr_seen_d;
      data_out_q  <= data_out_d;
      ack_valid_q <= ack_valid_d;
      my_id_q     <= my_id_d;
      id_valid_q  <= id_valid_d;
      err_id_q    <= err_id_d;
      timeout_q   <= timeout_d;
    end
  end

  assign data_out  = data_out_q;
  assign ack_valid = ack_valid_q;
  assign my_id     = my_id_q;
  assign id_valid  = id_valid_q;
  assign pwr_seen  = pwr_seen_q;
  assign err_id    = err_id_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_sort_responder.sv
// Self-checking bench for sort_responder: two instances with different
// parameters share the stimulus; a timing-level reference model predicts
// every output after each clock edge.
module tb_sort_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bottom = 1'b0;
  logic [31:0] data_in = '0;

  logic [31:0] dout_a, dout_b;
  logic        ackv_a, ackv_b, idv_a, idv_b, err_a, err_b, tmo_a, tmo_b;
  logic [3:0]  myid_a, myid_b, pwr_a, pwr_b;

  always #5 clk = ~clk;

  sort_responder #(
    .RESP_LAT(2), .ACK_HOLD(4), .MIN_PWR(4'd1), .TIMEOUT_CYC(1023)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .bottom(bottom), .data_in(data_in),
    .data_out(dout_a), .ack_valid(ackv_a), .my_id(myid_a), .id_valid(idv_a),
    .pwr_seen(pwr_a), .err_id(err_a), .timeout(tmo_a)
  );

  sort_responder #(
    .RESP_LAT(0), .ACK_HOLD(1), .MIN_PWR(4'd4), .TIMEOUT_CYC(16)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .bottom(bottom), .data_in(data_in),
    .data_out(dout_b), .ack_valid(ackv_b), .my_id(myid_b), .id_valid(idv_b),
    .pwr_seen(pwr_b), .err_id(err_b), .timeout(tmo_b)
  );

`ifdef SORT_RESP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per instance, track whether/when a request was
  // accepted; outputs follow from elapsed edges since acceptance.
  typedef enum {M_IDLE, M_ACC, M_BOT, M_TMO} mphase_e;
  int          p_lat[2]  = '{2, 0};
  int          p_hold[2] = '{4, 1};
  int          p_minp[2] = '{1, 4};
  int          p_to[2]   = '{1023, 16};
  int          ev;
  mphase_e     mph[2];
  int          tacc[2];
  logic [3:0]  mpwr[2], msrc[2], masg[2];
  bit          merr[2];

  task automatic model_reset();
    ev = 0;
    for (int d = 0; d < 2; d++) begin
      mph[d] = M_IDLE; merr[d] = 1'b0; tacc[d] = 0;
      mpwr[d] = '0; msrc[d] = '0; masg[d] = '0;
    end
  endtask

  task automatic model_edge(input logic b, input logic [31:0] w);
    logic [3:0] p, s, a, nx;
    bit hdr, idok;
    ev++;
    p = w[27:24]; s = w[23:20]; a = w[19:16]; nx = s + 4'd1;
    hdr  = (w[31:28] == 4'hA) && (w[15:0] == 16'hBEAF);
    idok = (a == nx) && (a != 4'd0);
    for (int d = 0; d < 2; d++) begin
      merr[d] = 1'b0;
      if (mph[d] == M_IDLE) begin
        if (b) mph[d] = M_BOT;
        else if (hdr && idok && int'(p) >= p_minp[d]) begin
          mph[d] = M_ACC; tacc[d] = ev; mpwr[d] = p; msrc[d] = s; masg[d] = a;
        end else begin
          if (hdr && !idok) merr[d] = 1'b1;
          if (TO_EN && ev == p_to[d]) mph[d] = M_TMO;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      int          ack_start, ack_end;
      logic        e_ackv, e_idv, e_tmo;
      logic [31:0] e_dout;
      logic [3:0]  e_myid, e_pwr;
      string       n;
      n = (d == 0) ? "a" : "b";
      ack_start = tacc[d] + p_lat[d] + 1;
      ack_end   = ack_start + p_hold[d];
      e_ackv = (mph[d] == M_ACC) && ev >= ack_start && ev < ack_end;
      e_dout = e_ackv ? {4'h5, mpwr[d], masg[d], msrc[d], 16'hBEAF} : 32'h0;
      e_idv  = (mph[d] == M_BOT) || ((mph[d] == M_ACC) && ev >= ack_end);
      e_myid = ((mph[d] == M_ACC) && ev >= ack_end) ? masg[d] : 4'h0;
      e_pwr  = (mph[d] == M_ACC) ? mpwr[d] : 4'h0;
      e_tmo  = (mph[d] == M_TMO);
      chk({n, ".data_out"},  d == 0 ? dout_a : dout_b, e_dout);
      chk({n, ".ack_valid"}, 32'(d == 0 ? ackv_a : ackv_b), 32'(e_ackv));
      chk({n, ".id_valid"},  32'(d == 0 ? idv_a : idv_b), 32'(e_idv));
      chk({n, ".my_id"},     32'(d == 0 ? myid_a : myid_b), 32'(e_myid));
      chk({n, ".pwr_seen"},  32'(d == 0 ? pwr_a : pwr_b), 32'(e_pwr));
      chk({n, ".err_id"},    32'(d == 0 ? err_a : err_b), 32'(merr[d]));
      chk({n, ".timeout"},   32'(d == 0 ? tmo_a : tmo_b), 32'(e_tmo));
    end
  endtask

  task automatic step(input logic b, input logic [31:0] w);
    bottom = b; data_in = w;
    @(posedge clk);
    model_edge(b, w);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bottom = 1'b0; data_in = '0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] req(input logic [3:0] p, input logic [3:0] s,
                                      input logic [3:0] a);
    return {4'hA, p, s, a, 16'hBEAF};
  endfunction

  typedef struct {
    logic        b;
    logic [31:0] w;
    logic        ackv;
    logic [31:0] dout;
    logic        err;
    logic        idv;
    logic [3:0]  myid;
    logic [3:0]  pwr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table for the default instance: accept, latency 2, hold 4, done.
    tbl[0] = '{1'b0, 32'hA301BEAF, 1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 4'h3};
    tbl[1] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 4'h3};
    tbl[2] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 4'h3};
    tbl[3] = '{1'b0, 32'h0,        1'b1, 32'h5310BEAF, 1'b0, 1'b0, 4'h0, 4'h3};
    tbl[4] = '{1'b0, 32'h0,        1'b1, 32'h5310BEAF, 1'b0, 1'b0, 4'h0, 4'h3};
    tbl[5] = '{1'b0, 32'h0,        1'b1, 32'h5310BEAF, 1'b0, 1'b0, 4'h0, 4'h3};
    tbl[6] = '{1'b0, 32'h0,        1'b1, 32'h5310BEAF, 1'b0, 1'b0, 4'h0, 4'h3};
    tbl[7] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 4'h1, 4'h3};
    tbl[8] = '{1'b0, 32'hA412BEAF, 1'b0, 32'h0,        1'b0, 1'b1, 4'h1, 4'h3};

    do_reset();
    chk("reset.data_out", dout_a, 32'h0);
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].b, tbl[i].w);
      chk($sformatf("tbl%0d.ack_valid", i), 32'(ackv_a), 32'(tbl[i].ackv));
      chk($sformatf("tbl%0d.data_out", i), dout_a, tbl[i].dout);
      chk($sformatf("tbl%0d.err_id", i), 32'(err_a), 32'(tbl[i].err));
      chk($sformatf("tbl%0d.id_valid", i), 32'(idv_a), 32'(tbl[i].idv));
      chk($sformatf("tbl%0d.my_id", i), 32'(myid_a), 32'(tbl[i].myid));
      chk($sformatf("tbl%0d.pwr_seen", i), 32'(pwr_a), 32'(tbl[i].pwr));
    end

    // Low-power request ignored by the MIN_PWR=4 instance, retry accepted.
    do_reset();
    step(1'b0, 32'hA301BEAF);
    chk("minpwr.no_err", 32'(err_b), 32'h0);
    step(1'b0, 32'hA401BEAF);
    step(1'b0, 32'h0);
    chk("minpwr.ack_frame", dout_b, 32'h5410BEAF);
    chk("minpwr.ack_valid", 32'(ackv_b), 32'h1);
    step(1'b0, 32'h0);
    chk("minpwr.my_id", 32'(myid_b), 32'h1);
    chk("minpwr.ack_gone", dout_b, 32'h0);

    // Bad ID assignment: one err pulse, then a good frame is accepted.
    do_reset();
    step(1'b0, 32'hA203BEAF);
    chk("badid.err_pulse", 32'(err_a), 32'h1);
    chk("badid.data_out", dout_a, 32'h0);
    step(1'b0, 32'hA201BEAF);
    chk("badid.err_clear", 32'(err_a), 32'h0);
    chk("badid.accepted", 32'(pwr_a), 32'h2);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0);
    chk("badid.my_id", 32'(myid_a), 32'h1);

    // src 15 wraps to asg 0: rejected; held 3 cycles gives 3 pulses.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'hA2F0BEAF);
      chk($sformatf("wrap.err%0d", i), 32'(err_a), 32'h1);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0);
    chk("wrap.no_id", 32'(idv_a), 32'h0);

    // Second request during WAIT ignored; reset during ACK aborts at once.
    do_reset();
    step(1'b0, 32'hA301BEAF);
    step(1'b0, 32'hA312BEAF);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    chk("abort.first_wins", dout_a, 32'h5310BEAF);
    step(1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("abort.data_out", dout_a, 32'h0);
    chk("abort.ack_valid", 32'(ackv_a), 32'h0);
    chk("abort.id_valid", 32'(idv_a), 32'h0);
    chk("abort.pwr_seen", 32'(pwr_a), 32'h0);
    do_reset();

    // Bottom layer: ID 0 one edge after release, never an ack.
    step(1'b1, 32'h0);
    chk("bottom.id_valid", 32'(idv_a), 32'h1);
    chk("bottom.my_id", 32'(myid_a), 32'h0);
    step(1'b0, 32'hA501BEAF);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
    chk("bottom.no_ack", 32'(ackv_a), 32'h0);

    // Idle bus: watchdog expiry at the 16th edge on the b instance.
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 32'h0);
      if (i == 15) chk("tmo.before", 32'(tmo_b), 32'h0);
      if (i == 16) begin
`ifdef SORT_RESP_TIMEOUT_EN
        chk("tmo.expired", 32'(tmo_b), 32'h1);
`else
        chk("tmo.tied_low", 32'(tmo_b), 32'h0);
`endif
        chk("tmo.id_valid", 32'(idv_b), 32'h0);
      end
    end

    // Valid request on the expiry cycle takes precedence.
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b0, 32'h0);
    step(1'b0, req(4'h5, 4'h6, 4'h7));
    chk("tmo.req_wins", 32'(tmo_b), 32'h0);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);

    // Randomized episodes against the model.
    for (int ep = 0; ep < 14; ep++) begin
      do_reset();
      for (int c = 0; c < 30; c++) begin
        int unsigned r;
        logic [3:0] p, s, a;
        logic [31:0] w;
        logic b;
        r = $urandom_range(0, 9);
        p = 4'($urandom); s = 4'($urandom); a = 4'($urandom);
        b = ($urandom_range(0, 19) == 0);
        case (r)
          0, 1, 2: w = 32'h0;
          3, 4, 5: w = req(p, s, s + 4'd1);
          6:       w = req(p, s, a);
          7:       w = $urandom;
          default: w = {4'hA, p, s, s + 4'd1, 16'hBEAE};
        endcase
        step(b, w);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
